// File: rtl/onehot_scan_sequencer.sv
// One-hot scan select generator for the 9:1 pixel mux, with dwell, valid/ready, continuous mode and abort.
// Optional position skipping is enabled by defining SCAN_SKIP_EN (adds the skip_mask port).
module onehot_scan_sequencer #(
    parameter int unsigned N     = 9,
    parameter int unsigned DWELL = 1,
    parameter int unsigned IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             cont,
    input  logic             abort,
    input  logic             ready,
`ifdef SCAN_SKIP_EN
    input  logic [N-1:0]     skip_mask,
`endif
    output logic [N-1:0]     sel,
    output logic [IDX_W-1:0] idx,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             cont_q, cont_d;
    logic [N-1:0]     sel_q, sel_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Mask seen at the start edge and mask governing the running pass
    logic [N-1:0]     mask_start;
    logic [N-1:0]     mask_cur;
    logic [N-1:0]     mask_first;

`ifdef SCAN_SKIP_EN
    logic [N-1:0]     mask_q, mask_d;

    assign mask_start = skip_mask;
    assign mask_cur   = mask_q;
`else
    assign mask_start = '0;
    assign mask_cur   = '0;
`endif

    assign mask_first = (state_q == S_IDLE) ? mask_start : mask_cur;

    // Lowest unmasked position, and next unmasked position above idx_q
    logic             first_ok;
    logic [IDX_W-1:0] first_pos;
    logic             next_ok;
    logic [IDX_W-1:0] next_pos;

    always_comb begin
        first_ok  = 1'b0;
        first_pos = '0;
        next_ok   = 1'b0;
        next_pos  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (!mask_first[i]) begin
                first_ok  = 1'b1;
                first_pos = IDX_W'(i);
            end
            if (!mask_cur[i] && (i > int'(idx_q))) begin
                next_ok  = 1'b1;
                next_pos = IDX_W'(i);
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            dwell_q <= '0;
            idx_q   <= '0;
            cont_q  <= 1'b0;
            sel_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dwell_q <= dwell_d;
            idx_q   <= idx_d;
            cont_q  <= cont_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef SCAN_SKIP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end
`endif

    // Next-state logic; abort always takes priority over start and advance
    always_comb begin
        state_d = state_q;
        dwell_d = dwell_q;
        idx_d   = idx_q;
        cont_d  = cont_q;
`ifdef SCAN_SKIP_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    cont_d  = cont;
`ifdef SCAN_SKIP_EN
                    mask_d  = skip_mask;
`endif
                    dwell_d = '0;
                    if (first_ok) begin
                        state_d = S_SCAN;
                        idx_d   = first_pos;
                    end else begin
                        state_d = S_DONE;
                        idx_d   = '0;
                    end
                end
            end
            S_SCAN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    dwell_d = '0;
                    idx_d   = '0;
                end else if (ready) begin
                    if (dwell_q == DW_W'(DWELL - 1)) begin
                        dwell_d = '0;
                        if (next_ok) begin
                            idx_d = next_pos;
                        end else if (cont_q) begin
                            idx_d = first_pos;
                        end else begin
                            state_d = S_DONE;
                            idx_d   = '0;
                        end
                    end else begin
                        dwell_d = dwell_q + DW_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                dwell_d = '0;
                idx_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                dwell_d = '0;
                idx_d   = '0;
            end
        endcase
    end

    // Registered output values derived from the upcoming state
    always_comb begin
        sel_d   = '0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        if (state_d == S_SCAN) begin
            sel_d   = N'(1) << idx_d;
            valid_d = 1'b1;
        end
        if (state_d != S_IDLE) begin
            busy_d = 1'b1;
        end
        if (state_d == S_DONE) begin
            done_d = 1'b1;
        end
    end

    assign sel   = sel_q;
    assign idx   = idx_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_onehot_scan_sequencer.sv
// Self-checking bench for onehot_scan_sequencer: DWELL=1 and DWELL=3 instances share stimulus.
// Skip-mask scenarios run only when SCAN_SKIP_EN is defined.
module tb_onehot_scan_sequencer;

    localparam int NP = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          st, co, ab, rd;
    logic [NP-1:0] mask;

    logic [NP-1:0] sel1, sel3;
    logic [3:0]    idx1, idx3;
    logic          valid1, valid3, busy1, busy3, done1, done3;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    onehot_scan_sequencer #(.N(NP), .DWELL(1), .IDX_W(4)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(st), .cont(co), .abort(ab), .ready(rd),
`ifdef SCAN_SKIP_EN
        .skip_mask(mask),
`endif
        .sel(sel1), .idx(idx1), .valid(valid1), .busy(busy1), .done(done1)
    );

    onehot_scan_sequencer #(.N(NP), .DWELL(3), .IDX_W(4)) u_d3 (
        .clk(clk), .rst_n(rst_n), .start(st), .cont(co), .abort(ab), .ready(rd),
`ifdef SCAN_SKIP_EN
        .skip_mask(mask),
`endif
        .sel(sel3), .idx(idx3), .valid(valid3), .busy(busy3), .done(done3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle 1=scanning 2=done, scan position and ready-count
    typedef struct {
        int            phase;
        int            pos;
        int            cnt;
        bit            cont;
        logic [NP-1:0] mask;
    } mst_t;

    function automatic int free_above(input logic [NP-1:0] m, input int above);
        for (int i = above + 1; i < NP; i++) if (!m[i]) return i;
        return -1;
    endfunction

    function automatic mst_t step(input mst_t s, input bit s_st, input bit s_co, input bit s_ab,
                                  input bit s_rd, input logic [NP-1:0] s_mask, input int dw);
        mst_t n = s;
        if (s.phase == 0) begin
            if (s_st && !s_ab) begin
`ifdef SCAN_SKIP_EN
                n.mask = s_mask;
`else
                n.mask = '0;
`endif
                n.cont = s_co;
                n.cnt  = 0;
                n.pos  = free_above(n.mask, -1);
                n.phase = (n.pos < 0) ? 2 : 1;
            end
        end else if (s.phase == 1) begin
            if (s_ab) begin
                n.phase = 0;
            end else if (s_rd) begin
                n.cnt = s.cnt + 1;
                if (n.cnt == dw) begin
                    n.cnt = 0;
                    if (free_above(s.mask, s.pos) >= 0) n.pos = free_above(s.mask, s.pos);
                    else if (s.cont) n.pos = free_above(s.mask, -1);
                    else n.phase = 2;
                end
            end
        end else begin
            n.phase = 0;
        end
        return n;
    endfunction

    function automatic logic [15:0] expv(input mst_t s);
        logic [NP-1:0] e_sel = '0;
        logic [3:0]    e_idx = '0;
        if (s.phase == 1) begin
            e_sel = NP'(1) << s.pos;
            e_idx = 4'(s.pos);
        end
        return {e_sel, e_idx, s.phase == 1, s.phase != 0, s.phase == 2};
    endfunction

    mst_t m1, m3;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 = '{0, 0, 0, 1'b0, '0};
            m3 = '{0, 0, 0, 1'b0, '0};
        end else begin
            m1 = step(m1, st, co, ab, rd, mask, 1);
            m3 = step(m3, st, co, ab, rd, mask, 3);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dwell1", {16'h0, sel1, idx1, valid1, busy1, done1}, {16'h0, expv(m1)});
            check("model_dwell3", {16'h0, sel3, idx3, valid3, busy3, done3}, {16'h0, expv(m3)});
        end
    end

    typedef struct {
        bit            vs, vc, va, vr;
        logic [NP-1:0] esel;
        logic [3:0]    eidx;
        bit            ev, eb, ed;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input bit vs, vc, va, vr, input logic [NP-1:0] esel,
                                input logic [3:0] eidx, input bit ev, eb, ed);
        vec_t v;
        v.vs = vs; v.vc = vc; v.va = va; v.vr = vr;
        v.esel = esel; v.eidx = eidx; v.ev = ev; v.eb = eb; v.ed = ed;
        return v;
    endfunction

    task automatic apply(input bit vs, vc, va, vr);
        st = vs; co = vc; ab = va; rd = vr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int hold;
        rst_n = 1'b0;
        st = 0; co = 0; ab = 0; rd = 0; mask = '0;

        // Handshake/abort scenarios for the DWELL=1 instance
        tbl.push_back(mk(0,0,0,1, 9'h000, 0, 0,0,0));
        tbl.push_back(mk(1,0,0,1, 9'h001, 0, 1,1,0));
        tbl.push_back(mk(1,0,0,1, 9'h002, 1, 1,1,0));
        tbl.push_back(mk(0,0,0,0, 9'h002, 1, 1,1,0));
        tbl.push_back(mk(0,0,0,1, 9'h004, 2, 1,1,0));
        tbl.push_back(mk(0,0,1,1, 9'h000, 0, 0,0,0));
        tbl.push_back(mk(1,0,1,1, 9'h000, 0, 0,0,0));
        tbl.push_back(mk(1,1,0,1, 9'h001, 0, 1,1,0));
        for (int i = 1; i < NP; i++) tbl.push_back(mk(0,0,0,1, NP'(1) << i, 4'(i), 1,1,0));
        tbl.push_back(mk(0,0,0,1, 9'h001, 0, 1,1,0));
        for (int i = 1; i <= 4; i++) tbl.push_back(mk(0,0,0,1, NP'(1) << i, 4'(i), 1,1,0));
        tbl.push_back(mk(0,0,1,1, 9'h000, 0, 0,0,0));
        tbl.push_back(mk(1,0,0,1, 9'h001, 0, 1,1,0));
        for (int i = 1; i < NP; i++) tbl.push_back(mk(0,0,0,1, NP'(1) << i, 4'(i), 1,1,0));
        tbl.push_back(mk(0,0,0,1, 9'h000, 0, 0,1,1));
        tbl.push_back(mk(0,0,0,1, 9'h000, 0, 0,0,0));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state_d1", {16'h0, sel1, idx1, valid1, busy1, done1}, 32'h0);
        check("reset_state_d3", {16'h0, sel3, idx3, valid3, busy3, done3}, 32'h0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        foreach (tbl[k]) begin
            apply(tbl[k].vs, tbl[k].vc, tbl[k].va, tbl[k].vr);
            check($sformatf("vec%0d", k), {16'h0, sel1, idx1, valid1, busy1, done1},
                  {16'h0, tbl[k].esel, tbl[k].eidx, tbl[k].ev, tbl[k].eb, tbl[k].ed});
        end
        apply(0,0,1,0);

        // Asynchronous reset in the middle of a scan at sel=010
        apply(1,0,0,1);
        repeat (4) apply(0,0,0,1);
        check("pre_reset_sel", {23'h0, sel1}, 32'h010);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_sel", {23'h0, sel1}, 32'h0);
        check("async_rst_valid", {31'h0, valid1}, 32'h0);
        check("async_rst_busy", {31'h0, busy1}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // DWELL=3 with ready alternating: first position lasts 5 cycles
        apply(1,0,0,0);
        hold = 0;
        for (int k = 0; k < 12; k++) begin
            if (sel3 == 9'h001) hold++;
            check("dwell3_idx_tracks_sel", {23'h0, sel3}, {23'h0, valid3 ? (NP'(1) << idx3) : NP'(0)});
            apply(0, 0, 0, (k % 2) == 0);
        end
        check("dwell3_hold_cycles", hold, 5);
        apply(0,0,1,0);
        apply(0,0,0,0);

`ifdef SCAN_SKIP_EN
        mask = 9'h0F5;
        apply(1,0,0,1);
        check("skip_first", {23'h0, sel1}, 32'h002);
        apply(0,0,0,1);
        check("skip_second", {23'h0, sel1}, 32'h008);
        apply(0,0,0,1);
        check("skip_third", {23'h0, sel1}, 32'h100);
        apply(0,0,0,1);
        check("skip_done", {22'h0, sel1, done1}, 32'h1);
        apply(0,0,0,1);
        check("skip_idle", {30'h0, busy1, done1}, 32'h0);
        mask = 9'h1FF;
        apply(1,0,0,1);
        check("allmask_done", {30'h0, valid1, done1}, 32'h1);
        apply(0,0,0,1);
        check("allmask_idle", {29'h0, valid1, busy1, done1}, 32'h0);
`endif

        // Randomized traffic checked by the reference model
        for (int k = 0; k < 3000; k++) begin
            mask = NP'($urandom) & NP'($urandom);
            apply($urandom_range(0, 9) < 3, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 7);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
